// File: rtl/rf_pkg.sv
// Shared constants and state encoding for the RF emulation path (capture and emulator sides).
package rf_pkg;

  localparam int DATA_W = 128;
  localparam int DEPTH  = 64;
  localparam int ADDR_W = $clog2(DEPTH);
  localparam int KEEP_W = DATA_W / 8;
  localparam int LEN_W  = ADDR_W + 1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_DRAIN   = 2'd2
  } cap_state_t;

  // A zero or oversized request means a full buffer.
  function automatic logic [LEN_W-1:0] frame_len(input logic [LEN_W-1:0] req);
    if (req == '0 || req > LEN_W'(DEPTH)) return LEN_W'(DEPTH);
    return req;
  endfunction

endpackage

// File: rtl/rf_sdp_ram.sv
// Simple dual-port memory: one write port, one registered read port, array not reset.
module rf_sdp_ram
  import rf_pkg::*;
#(
  parameter int WIDTH = DATA_W,
  parameter int AW    = ADDR_W
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/rf_capture.sv
// Capture buffer: stores one frame from the datapath, then streams it to the DMA S2MM port
// as an AXI4-Stream packet through a 2-entry skid FIFO fed by the registered RAM read.
module rf_capture
  import rf_pkg::*;
(
  input  logic              clk,
  input  logic              rstn,
  input  logic              Arm,
  input  logic [LEN_W-1:0]  CapLen,
  input  logic [DATA_W-1:0] cap_data,
  input  logic              cap_valid,
  output logic              cap_ready,
  output logic [DATA_W-1:0] S_AXIS_S2MM_tdata,
  output logic [KEEP_W-1:0] S_AXIS_S2MM_tkeep,
  output logic              S_AXIS_S2MM_tlast,
  output logic              S_AXIS_S2MM_tvalid,
  input  logic              S_AXIS_S2MM_tready,
  output logic              Busy,
  output logic              Done
);

  cap_state_t        state, state_next;
  logic [LEN_W-1:0]  len, wr_cnt, rd_cnt;
  logic              rd_vld;
  logic [LEN_W-1:0]  rd_idx;
  logic [DATA_W-1:0] ram_q;
  logic [DATA_W-1:0] fifo_data [2];
  logic [LEN_W-1:0]  fifo_idx [2];
  logic              fifo_wp, fifo_rp;
  logic [1:0]        fifo_cnt;
  logic              arm_ok, wr_en, rd_en, pop, push, fifo_pop, last_acc;
  logic              head_valid, head_last;
  logic [DATA_W-1:0] head_data;
  logic [LEN_W-1:0]  head_idx;

  rf_sdp_ram #(.WIDTH(DATA_W), .AW(ADDR_W)) u_ram (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wr_cnt[ADDR_W-1:0]),
    .wr_data (cap_data),
    .rd_en   (rd_en),
    .rd_addr (rd_cnt[ADDR_W-1:0]),
    .rd_data (ram_q)
  );

  // When the FIFO is empty the freshly read beat is presented directly; if it is not
  // accepted it is pushed so the FIFO keeps it stable from the next cycle on.
  always_comb begin
    head_valid = (fifo_cnt != 2'd0) || rd_vld;
    head_data  = (fifo_cnt != 2'd0) ? fifo_data[fifo_rp] : ram_q;
    head_idx   = (fifo_cnt != 2'd0) ? fifo_idx[fifo_rp] : rd_idx;
    head_last  = head_valid && (head_idx == len - LEN_W'(1));
    pop        = head_valid && S_AXIS_S2MM_tready;
    push       = rd_vld && !((fifo_cnt == 2'd0) && pop);
    fifo_pop   = pop && (fifo_cnt != 2'd0);
    last_acc   = pop && head_last;
    wr_en      = (state == ST_CAPTURE) && cap_valid;
    rd_en      = (state == ST_DRAIN) && (rd_cnt < len) && ((2'(rd_vld) + fifo_cnt) < 2'd2);
    // Arm is ignored during the Done cycle, so a new capture opens two cycles after Done.
    arm_ok     = (state == ST_IDLE) && Arm && !Done;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:    if (arm_ok) state_next = ST_CAPTURE;
      ST_CAPTURE: if (wr_en && (wr_cnt == len - LEN_W'(1))) state_next = ST_DRAIN;
      ST_DRAIN:   if (last_acc) state_next = ST_IDLE;
      default:    state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      len    <= '0;
      wr_cnt <= '0;
      rd_cnt <= '0;
      rd_vld <= 1'b0;
      rd_idx <= '0;
      Done   <= 1'b0;
    end else begin
      Done   <= last_acc;
      rd_vld <= rd_en;
      if (arm_ok) begin
        len    <= frame_len(CapLen);
        wr_cnt <= '0;
        rd_cnt <= '0;
      end
      if (wr_en) wr_cnt <= wr_cnt + LEN_W'(1);
      if (rd_en) begin
        rd_idx <= rd_cnt;
        rd_cnt <= rd_cnt + LEN_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      fifo_wp  <= 1'b0;
      fifo_rp  <= 1'b0;
      fifo_cnt <= 2'd0;
    end else begin
      if (push) fifo_wp <= ~fifo_wp;
      if (fifo_pop) fifo_rp <= ~fifo_rp;
      fifo_cnt <= fifo_cnt + 2'(push) - 2'(fifo_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data[fifo_wp] <= ram_q;
      fifo_idx[fifo_wp]  <= rd_idx;
    end
  end

  always_comb begin
    cap_ready          = (state == ST_CAPTURE);
    Busy               = (state != ST_IDLE);
    S_AXIS_S2MM_tvalid = head_valid;
    S_AXIS_S2MM_tdata  = head_valid ? head_data : '0;
    S_AXIS_S2MM_tkeep  = head_valid ? {KEEP_W{1'b1}} : '0;
    S_AXIS_S2MM_tlast  = head_last;
  end

endmodule

// File: tb/tb_rf_capture.sv
// Directed bench for rf_capture: frames of length 4, 1, 64, 8 (with output stalls),
// ignored Arm/cap_valid outside their windows, and asynchronous reset mid-drain.
module tb_rf_capture;

  logic         clk = 1'b0;
  logic         rstn = 1'b0;
  logic         Arm = 1'b0;
  logic [6:0]   CapLen = '0;
  logic [127:0] cap_data = '0;
  logic         cap_valid = 1'b0;
  logic         cap_ready;
  logic [127:0] tdata;
  logic [15:0]  tkeep;
  logic         tlast, tvalid;
  logic         tready = 1'b0;
  logic         Busy, Done;

  int tests = 0;
  int fails = 0;

  rf_capture dut (
    .clk                (clk),
    .rstn               (rstn),
    .Arm                (Arm),
    .CapLen             (CapLen),
    .cap_data           (cap_data),
    .cap_valid          (cap_valid),
    .cap_ready          (cap_ready),
    .S_AXIS_S2MM_tdata  (tdata),
    .S_AXIS_S2MM_tkeep  (tkeep),
    .S_AXIS_S2MM_tlast  (tlast),
    .S_AXIS_S2MM_tvalid (tvalid),
    .S_AXIS_S2MM_tready (tready),
    .Busy               (Busy),
    .Done               (Done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic apply_stimulus(input logic [127:0] data);
    cap_data  = data;
    cap_valid = 1'b1;
    tick();
  endtask

  function automatic logic [127:0] pat(input int i);
    return {32'hC0DE_0000 | 32'(i), ~32'(i), 32'(i) * 32'd3, 32'(i) << 4};
  endfunction

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [127:0] exp8 [8];
    logic [15:0]  stall_bits;
    logic [127:0] held_data;
    logic         held;
    int           k;

    stall_bits = 16'b1001_1010_0011_0101;

    // Reset values
    tick(); tick();
    check_output("rst_cap_ready", cap_ready, 0);
    check_output("rst_tvalid", tvalid, 0);
    check_output("rst_tlast", tlast, 0);
    check_output("rst_tkeep", tkeep, 0);
    check_output("rst_tdata", tdata, 0);
    check_output("rst_busy", Busy, 0);
    check_output("rst_done", Done, 0);
    rstn = 1'b1;
    tick();

    // CapLen=4, beats 1..4, tready high
    tready = 1'b1;
    Arm = 1'b1; CapLen = 7'd4;
    tick();
    Arm = 1'b0;
    check_output("f4_cap_ready", cap_ready, 1);
    check_output("f4_busy", Busy, 1);
    for (int i = 1; i <= 4; i++) apply_stimulus(128'(i));
    cap_valid = 1'b0;
    check_output("f4_ready_low", cap_ready, 0);
    check_output("f4_no_early_valid", tvalid, 0);
    tick();
    for (int i = 1; i <= 4; i++) begin
      check_output("f4_valid", tvalid, 1);
      check_output("f4_data", tdata, 128'(i));
      check_output("f4_last", tlast, (i == 4));
      check_output("f4_keep", tkeep, 16'hFFFF);
      tick();
    end
    check_output("f4_done", Done, 1);
    check_output("f4_busy_low", Busy, 0);
    check_output("f4_valid_low", tvalid, 0);

    // Arm during the Done cycle is ignored; held one more cycle it starts CapLen=1
    Arm = 1'b1; CapLen = 7'd1;
    tick();
    check_output("rearm_not_yet", cap_ready, 0);
    check_output("done_one_cycle", Done, 0);
    tick();
    Arm = 1'b0;
    check_output("rearm_ready", cap_ready, 1);
    apply_stimulus(128'hDEAD_BEEF_0123_4567_89AB_CDEF_5555_AAAA);
    cap_valid = 1'b0;
    check_output("f1_ready_low", cap_ready, 0);
    tick();
    check_output("f1_valid", tvalid, 1);
    check_output("f1_last", tlast, 1);
    check_output("f1_keep", tkeep, 16'hFFFF);
    check_output("f1_data", tdata, 128'hDEAD_BEEF_0123_4567_89AB_CDEF_5555_AAAA);
    tick();
    check_output("f1_done", Done, 1);
    check_output("f1_valid_low", tvalid, 0);
    tick();

    // CapLen=0 means a full 64-beat frame
    Arm = 1'b1; CapLen = 7'd0;
    tick();
    Arm = 1'b0;
    for (int i = 0; i < 64; i++) apply_stimulus(pat(i));
    cap_valid = 1'b0;
    check_output("f64_ready_low", cap_ready, 0);
    tick();
    for (int i = 0; i < 64; i++) begin
      check_output("f64_valid", tvalid, 1);
      check_output("f64_data", tdata, pat(i));
      check_output("f64_last", tlast, (i == 63));
      tick();
    end
    check_output("f64_done", Done, 1);
    check_output("f64_valid_low", tvalid, 0);
    tick();

    // CapLen=8 with stray cap_valid/Arm and a stalling sink
    for (int i = 0; i < 8; i++) exp8[i] = {4{32'h8000_0000 | 32'(i * 17)}};
    cap_data = {4{32'hBAD0_BAD0}}; cap_valid = 1'b1;
    tick(); tick();
    Arm = 1'b1; CapLen = 7'd8;
    tick();
    Arm = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (i == 3) begin Arm = 1'b1; CapLen = 7'd3; end
      apply_stimulus(exp8[i]);
      Arm = 1'b0;
      if (i % 2 == 1 && i != 7) begin
        cap_valid = 1'b0; cap_data = {4{32'hBAD1_BAD1}};
        tick();
      end
    end
    cap_valid = 1'b1; cap_data = {4{32'hBAD2_BAD2}};
    check_output("f8_drain_ready_low", cap_ready, 0);
    k = 0; held = 1'b0; held_data = '0;
    for (int cyc = 0; cyc < 200 && k < 8; cyc++) begin
      tready = stall_bits[cyc % 16];
      Arm = (cyc == 2);
      CapLen = 7'd2;
      #1;
      if (held) begin
        check_output("f8_stall_valid", tvalid, 1);
        check_output("f8_stall_data", tdata, held_data);
      end
      if (tvalid && tready) begin
        check_output("f8_data", tdata, exp8[k]);
        check_output("f8_last", tlast, (k == 7));
        k++;
        held = 1'b0;
      end else if (tvalid) begin
        held = 1'b1;
        held_data = tdata;
      end
      tick();
    end
    Arm = 1'b0;
    cap_valid = 1'b0;
    check_output("f8_accept_count", 128'(k), 128'd8);
    check_output("f8_done", Done, 1);
    check_output("f8_valid_low", tvalid, 0);
    tick();
    check_output("f8_idle", Busy, 0);

    // Reset mid-drain with tvalid high, then a clean 2-beat frame
    tready = 1'b0;
    Arm = 1'b1; CapLen = 7'd4;
    tick();
    Arm = 1'b0;
    for (int i = 0; i < 4; i++) apply_stimulus(128'h100 + 128'(i));
    cap_valid = 1'b0;
    tick();
    check_output("rd_pre_valid", tvalid, 1);
    #2;
    rstn = 1'b0;
    #1;
    check_output("rd_tvalid", tvalid, 0);
    check_output("rd_tdata", tdata, 0);
    check_output("rd_tlast", tlast, 0);
    check_output("rd_tkeep", tkeep, 0);
    check_output("rd_busy", Busy, 0);
    check_output("rd_cap_ready", cap_ready, 0);
    check_output("rd_done", Done, 0);
    tick();
    rstn = 1'b1;
    tick();
    tready = 1'b1;
    Arm = 1'b1; CapLen = 7'd2;
    tick();
    Arm = 1'b0;
    check_output("r2_ready", cap_ready, 1);
    apply_stimulus(128'h2222);
    apply_stimulus(128'h3333);
    cap_valid = 1'b0;
    tick();
    check_output("r2_valid0", tvalid, 1);
    check_output("r2_data0", tdata, 128'h2222);
    check_output("r2_last0", tlast, 0);
    tick();
    check_output("r2_data1", tdata, 128'h3333);
    check_output("r2_last1", tlast, 1);
    tick();
    check_output("r2_done", Done, 1);
    check_output("r2_valid_low", tvalid, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
